// File: rtl/ctrl_sw_pkg.sv
// Shared definitions for the sequencer control-source switch: FSM states,
// control-line bit positions and the default safe/inversion patterns.
package ctrl_sw_pkg;

  typedef enum logic [1:0] {
    ST_HOLD   = 2'd0,
    ST_GUARD  = 2'd1,
    ST_ACTIVE = 2'd2
  } sw_state_e;

  localparam int unsigned BIT_INTERRUPT = 0;
  localparam int unsigned BIT_RT_SW     = 1;
  localparam int unsigned BIT_SOFT_DUMP = 2;
  localparam int unsigned BIT_SW_ACQ1   = 3;
  localparam int unsigned BIT_SW_ACQ2   = 4;

  localparam int unsigned DEF_NSIG = BIT_SW_ACQ2 + 1;

  // interrupt is active-low at the source; sw_acq1/2 park high when safe
  localparam logic [DEF_NSIG-1:0] DEF_INV_MASK = DEF_NSIG'(1) << BIT_INTERRUPT;
  localparam logic [DEF_NSIG-1:0] DEF_SAFE_VAL =
    (DEF_NSIG'(1) << BIT_SW_ACQ1) | (DEF_NSIG'(1) << BIT_SW_ACQ2);

endpackage

// File: rtl/ctrl_src_switch_if.sv
// Select/source/control bundle between the DSP side and the source switch.
interface ctrl_src_switch_if #(
  parameter int unsigned NSRC = 3,
  parameter int unsigned NSIG = 5,
  parameter int unsigned SELW = 2
);
  logic [SELW-1:0]      sel;
  logic [NSRC*NSIG-1:0] src_in;
  logic                 force_safe;
  logic [NSIG-1:0]      ctrl_out;
  logic [SELW-1:0]      active_src;
  logic                 src_valid;
  logic                 switch_done;
  logic                 sel_err;

  modport master (
    output sel, src_in, force_safe,
    input  ctrl_out, active_src, src_valid, switch_done, sel_err
  );

  modport slave (
    input  sel, src_in, force_safe,
    output ctrl_out, active_src, src_valid, switch_done, sel_err
  );
endinterface

// File: rtl/ctrl_src_switch_sel_sync_debounce.sv
// Two-flop synchroniser for the asynchronous select followed by a debouncer
// that accepts a value after STABLE consecutive equal synchronised samples.
module sel_sync_debounce #(
  parameter int unsigned SELW   = 2,
  parameter int unsigned STABLE = 4
) (
  input  logic            clk_sys,
  input  logic            rst_n,
  input  logic [SELW-1:0] sel_i,
  output logic [SELW-1:0] sel_acc_o,
  output logic            sel_acc_vld_o,
  output logic            acc_stb_o
);
  localparam int unsigned   CW      = $clog2(STABLE + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE);

  logic [SELW-1:0] s1_q, s2_q, cand_q, acc_q;
  logic [1:0]      smp_vld_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            acc_vld_q, stb_q, hit;

  // Post-reset contents of the sync flops are not real samples; smp_vld_q
  // keeps them out of the count so reset cannot shortcut the debounce.
  always_comb begin
    cnt_d = cnt_q;
    hit   = 1'b0;
    if (smp_vld_q[1]) begin
      if ((s2_q != cand_q) || (cnt_q == '0)) begin
        cnt_d = CW'(1);
        hit   = (CNT_MAX == CW'(1));
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CW'(1);
        hit   = (cnt_d == CNT_MAX);
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      s1_q      <= '0;
      s2_q      <= '0;
      smp_vld_q <= '0;
      cand_q    <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      acc_vld_q <= 1'b0;
      stb_q     <= 1'b0;
    end else begin
      s1_q      <= sel_i;
      s2_q      <= s1_q;
      smp_vld_q <= {smp_vld_q[0], 1'b1};
      if (smp_vld_q[1]) cand_q <= s2_q;
      cnt_q     <= cnt_d;
      stb_q     <= hit;
      if (hit) begin
        acc_q     <= s2_q;
        acc_vld_q <= 1'b1;
      end
    end
  end

  assign sel_acc_o     = acc_q;
  assign sel_acc_vld_o = acc_vld_q;
  assign acc_stb_o     = stb_q;

endmodule

// File: rtl/ctrl_src_switch.sv
// Glitch-free switch routing one of NSRC sequencer control groups to the
// shared acquisition control lines, with a safe-level guard on every change.
module ctrl_src_switch
  import ctrl_sw_pkg::*;
#(
  parameter int unsigned     NSRC     = 3,
  parameter int unsigned     NSIG     = DEF_NSIG,
  parameter int unsigned     SELW     = 2,
  parameter int unsigned     STABLE   = 4,
  parameter int unsigned     GUARD    = 8,
  parameter logic [NSIG-1:0] INV_MASK = NSIG'(DEF_INV_MASK),
  parameter logic [NSIG-1:0] SAFE_VAL = NSIG'(DEF_SAFE_VAL)
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  ctrl_src_switch_if.slave  bus
);
  localparam int unsigned GCW = $clog2(GUARD + 1);

  logic [SELW-1:0] sel_acc;
  logic            sel_acc_vld, acc_stb, acc_in_range, sel_ok;

  sel_sync_debounce #(
    .SELW   (SELW),
    .STABLE (STABLE)
  ) u_sel (
    .clk_sys       (clk_sys),
    .rst_n         (rst_n),
    .sel_i         (bus.sel),
    .sel_acc_o     (sel_acc),
    .sel_acc_vld_o (sel_acc_vld),
    .acc_stb_o     (acc_stb)
  );

  assign acc_in_range = (32'(sel_acc) < NSRC);
  assign sel_ok       = sel_acc_vld && acc_in_range;

  sw_state_e       state_q;
  logic [SELW-1:0] target_q, active_src_q;
  logic [GCW-1:0]  guard_q;
  logic [NSIG-1:0] ctrl_q, route;
  logic            valid_q, done_q, err_q;

  // In ACTIVE target_q equals active_src_q, so one mux serves both the
  // ACTIVE-entry load and steady-state tracking.
  always_comb begin
    route = '0;
    for (int unsigned k = 0; k < NSRC; k++) begin
      if (target_q == SELW'(k)) route = bus.src_in[k*NSIG +: NSIG];
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state_q      <= ST_HOLD;
      target_q     <= '0;
      active_src_q <= '0;
      guard_q      <= '0;
      ctrl_q       <= SAFE_VAL;
      valid_q      <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= acc_stb && !acc_in_range;
      if (bus.force_safe) begin
        state_q <= ST_HOLD;
        ctrl_q  <= SAFE_VAL;
        valid_q <= 1'b0;
      end else begin
        unique case (state_q)
          ST_HOLD: begin
            ctrl_q  <= SAFE_VAL;
            valid_q <= 1'b0;
            if (sel_ok) begin
              state_q  <= ST_GUARD;
              target_q <= sel_acc;
              guard_q  <= GCW'(GUARD);
            end
          end
          ST_GUARD: begin
            ctrl_q  <= SAFE_VAL;
            valid_q <= 1'b0;
            // a retarget wins even in the last guard cycle
            if (sel_ok && (sel_acc != target_q)) begin
              target_q <= sel_acc;
              guard_q  <= GCW'(GUARD);
            end else if (guard_q <= GCW'(1)) begin
              state_q      <= ST_ACTIVE;
              active_src_q <= target_q;
              ctrl_q       <= route ^ INV_MASK;
              valid_q      <= 1'b1;
              done_q       <= 1'b1;
            end else begin
              guard_q <= guard_q - GCW'(1);
            end
          end
          ST_ACTIVE: begin
            if (sel_ok && (sel_acc != active_src_q)) begin
              state_q  <= ST_GUARD;
              target_q <= sel_acc;
              guard_q  <= GCW'(GUARD);
              ctrl_q   <= SAFE_VAL;
              valid_q  <= 1'b0;
            end else begin
              ctrl_q  <= route ^ INV_MASK;
              valid_q <= 1'b1;
            end
          end
          default: begin
            state_q <= ST_HOLD;
            ctrl_q  <= SAFE_VAL;
            valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.ctrl_out    = ctrl_q;
  assign bus.active_src  = active_src_q;
  assign bus.src_valid   = valid_q;
  assign bus.switch_done = done_q;
  assign bus.sel_err     = err_q;

endmodule
